// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a single-outstanding request/response port into
// APB SETUP/ACCESS transfers and returns read data and error status.
// Optional macro APB_TIMEOUT_EN: aborts an ACCESS phase after TIMEOUT_CYCLES
// consecutive PREADY-low cycles and reports it as an error response.
module apb_master_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic                  req_we_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PSLVERR
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   // Elaboration-time guard on the timeout range
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 2..65535");
   end

   state_t                state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q, resp_err_d;
`ifdef APB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]           cnt_q, cnt_d;
`endif

   // Next-state and registered-output decode
   always_comb begin
      state_d      = state_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
`ifdef APB_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               paddr_d   = req_addr_i;
               pwrite_d  = req_we_i;
               pwdata_d  = req_wdata_i;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         ST_ACCESS: begin
            if (PREADY) begin
               resp_rdata_d = pwrite_q ? '0 : PRDATA;
               resp_err_d   = PSLVERR;
               psel_d       = 1'b0;
               penable_d    = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end
`ifdef APB_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               resp_rdata_d = '0;
               resp_err_d   = 1'b1;
               psel_d       = 1'b0;
               penable_d    = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         ST_RESP: begin
            if (resp_ready_i) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q      <= ST_IDLE;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
`ifdef APB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE);
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_err_o   = resp_err_q;
   assign PADDR        = paddr_q;
   assign PSEL         = psel_q;
   assign PENABLE      = penable_q;
   assign PWRITE       = pwrite_q;
   assign PWDATA       = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: acts as requester and APB slave,
// expected responses go through a scoreboard queue.
module tb_apb_master_bridge;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i;
   logic          req_we_i;
   logic [DW-1:0] req_wdata_i;
   logic          resp_valid_o;
   logic          resp_ready_i;
   logic [DW-1:0] resp_rdata_o;
   logic          resp_err_o;
   logic [AW-1:0] PADDR;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [DW-1:0] PWDATA;
   logic          PREADY;
   logic [DW-1:0] PRDATA;
   logic          PSLVERR;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } resp_t;
   resp_t sb_q[$];

   apb_master_bridge #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_we_i    (req_we_i),
      .req_wdata_i (req_wdata_i),
      .resp_valid_o(resp_valid_o),
      .resp_ready_i(resp_ready_i),
      .resp_rdata_o(resp_rdata_o),
      .resp_err_o  (resp_err_o),
      .PADDR       (PADDR),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PWDATA      (PWDATA),
      .PREADY      (PREADY),
      .PRDATA      (PRDATA),
      .PSLVERR     (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Pop the scoreboard on a response handshake and compare
   task automatic sb_pop(input string tag);
      resp_t e;
      check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "_rdata"}, 64'(resp_rdata_o), 64'(e.rdata));
         check({tag, "_err"}, 64'(resp_err_o), 64'(e.err));
      end
   endtask

   // One transfer; caller is 1 time unit after a rising edge, DUT in IDLE.
   // bp > 0 stalls the response and holds a next request pending meanwhile.
   task automatic xfer(input string tag, input logic [AW-1:0] addr, input logic we,
                       input logic [DW-1:0] wdata, input int unsigned waits,
                       input logic [DW-1:0] rdata, input logic err, input int unsigned bp);
      resp_t e;
      int unsigned en_cycles;
      e.rdata = we ? '0 : rdata;
      e.err   = err;
      sb_q.push_back(e);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_we_i    = we;
      req_wdata_i = wdata;
      PREADY      = 1'b1;  // ignored outside ACCESS
      PRDATA      = 32'hBAD0_BAD0;
      PSLVERR     = 1'b1;
      resp_ready_i = (bp == 0);
      check({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
      tick();  // edge 0: accepted
      req_valid_i = 1'b0;
      req_addr_i  = ~addr;
      req_wdata_i = ~wdata;
      check({tag, "_setup_sel_en"}, {62'd0, PSEL, PENABLE}, 64'b10);
      check({tag, "_paddr"}, 64'(PADDR), 64'(addr));
      check({tag, "_pwrite"}, 64'(PWRITE), 64'(we));
      check({tag, "_pwdata"}, 64'(PWDATA), 64'(wdata));
      PREADY = 1'b0;
      tick();  // edge 1: ACCESS
      en_cycles = 0;
      for (int unsigned i = 0; i <= waits; i++) begin
         if (PSEL && PENABLE) en_cycles++;
         if (PADDR !== addr || PWDATA !== wdata || PWRITE !== we)
            check({tag, "_stable"}, {PADDR, PWDATA}, {addr, wdata});
         PREADY  = (i == waits);
         PRDATA  = (i == waits) ? rdata : 32'h5555_AAAA;
         PSLVERR = (i == waits) ? err : 1'b1;
         tick();
      end
      PREADY  = 1'b0;
      PRDATA  = 32'h0F0F_0F0F;
      PSLVERR = 1'b1;
      check({tag, "_enable_cycles"}, 64'(en_cycles), 64'(waits + 1));
      check({tag, "_resp_valid_sel"}, {61'd0, resp_valid_o, PSEL, PENABLE}, 64'b100);
      for (int unsigned i = 0; i < bp; i++) begin
         req_valid_i = 1'b1;
         req_addr_i  = 32'h0000_0030;
         req_we_i    = 1'b1;
         req_wdata_i = 32'h0000_CAFE;
         if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || PSEL !== 1'b0 ||
             resp_rdata_o !== e.rdata || resp_err_o !== e.err)
            check({tag, "_bp_hold"}, {resp_valid_o, req_ready_o, PSEL, resp_err_o},
                  {1'b1, 1'b0, 1'b0, e.err});
         tick();
      end
      if (bp != 0) begin
         check({tag, "_bp_still_valid"}, {62'd0, resp_valid_o, req_ready_o}, 64'b10);
         resp_ready_i = 1'b1;
      end
      sb_pop(tag);
      tick();  // handshake edge: back to IDLE
      check({tag, "_idle"}, {62'd0, resp_valid_o, req_ready_o}, 64'b01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      PRESET = 1'b1;
      req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0; req_wdata_i = '0;
      resp_ready_i = 1'b1;
      PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
      tick(); tick();
      check("rst_apb", {PADDR, PWDATA}, 64'd0);
      check("rst_ctl", {59'd0, PSEL, PENABLE, PWRITE, resp_valid_o, resp_err_o}, 64'd0);
      check("rst_rdata", 64'(resp_rdata_o), 64'd0);
      PRESET = 1'b0;
      #1;
      check("rst_ready", 64'(req_ready_o), 64'd1);
      tick();

      xfer("wr0", 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, 32'h1111_1111, 1'b0, 0);
      xfer("rd3", 32'h0000_0024, 1'b0, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 0);
      check("addr_kept", 64'(PADDR), 64'h24);
      xfer("slverr", 32'h0000_0028, 1'b0, 32'h0, 0, 32'hFFFF_FFFF, 1'b1, 0);
      xfer("bp", 32'h0000_002C, 1'b0, 32'h0, 1, 32'hA5A5_0001, 1'b0, 5);
      xfer("bp_next", 32'h0000_0030, 1'b1, 32'h0000_CAFE, 2, 32'h0, 1'b0, 0);

      // Reset mid-ACCESS
      req_valid_i = 1'b1; req_addr_i = 32'h44; req_we_i = 1'b0; req_wdata_i = '0;
      PREADY = 1'b0;
      tick();
      req_valid_i = 1'b0;
      tick(); tick();
      check("midrst_pre", {62'd0, PSEL, PENABLE}, 64'b11);
      PRESET = 1'b1;
      tick();
      check("midrst_post", {61'd0, PSEL, PENABLE, resp_valid_o}, 64'd0);
      PRESET = 1'b0;
      #1;
      check("midrst_ready", 64'(req_ready_o), 64'd1);
      tick();

      // PREADY held low
      req_valid_i = 1'b1; req_addr_i = 32'h40; req_we_i = 1'b0;
      PREADY = 1'b0;
      tick();
      req_valid_i = 1'b0;
      tick();
      n = 0;
`ifdef APB_TIMEOUT_EN
      sb_q.push_back('{rdata: '0, err: 1'b1});
      while (PENABLE && n < 50) begin
         n++;
         tick();
      end
      check("to_cycles", 64'(n), 64'd8);
      check("to_resp", {62'd0, resp_valid_o, PSEL}, 64'b10);
      sb_pop("to");
      tick();
      check("to_idle", 64'(req_ready_o), 64'd1);
`else
      while (PENABLE && PSEL && n < 1000) begin
         n++;
         tick();
      end
      check("noto_cycles", 64'(n), 64'd1000);
      check("noto_access", {61'd0, PSEL, PENABLE, resp_valid_o}, 64'b110);
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      #1;
      check("noto_ready", 64'(req_ready_o), 64'd1);
`endif
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
